// File: rtl/imem_loader_pkg.sv
// Shared MIPS encoding definitions for the program loader: field positions,
// the legal opcode set and the pure encode helpers.
package imem_loader_pkg;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // One bit per opcode value; set bits are the opcodes the loader can encode.
    localparam logic [63:0] LEGAL_OP_MASK =
        (64'd1 << 6'h00) | (64'd1 << 6'h02) | (64'd1 << 6'h03) |
        (64'd1 << 6'h04) | (64'd1 << 6'h05) | (64'd1 << 6'h08) |
        (64'd1 << 6'h09) | (64'd1 << 6'h0A) | (64'd1 << 6'h0B) |
        (64'd1 << 6'h0C) | (64'd1 << 6'h0D) | (64'd1 << 6'h0F) |
        (64'd1 << 6'h23) | (64'd1 << 6'h24) | (64'd1 << 6'h25) |
        (64'd1 << 6'h28) | (64'd1 << 6'h2B) | (64'd1 << 6'h30) |
        (64'd1 << 6'h38);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } load_state_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return LEGAL_OP_MASK[op];
    endfunction

    function automatic logic [31:0] encode_instr(input instr_fields_t f);
        logic [31:0] w;
        case (f.opcode)
            OP_RTYPE: w = (32'(f.opcode) << OP_LSB) | (32'(f.rs) << RS_LSB) |
                          (32'(f.rt) << RT_LSB) | (32'(f.rd) << RD_LSB) |
                          (32'(f.shamt) << SHAMT_LSB) | 32'(f.funct);
            OP_J, OP_JAL: w = (32'(f.opcode) << OP_LSB) | 32'(f.target);
            default:  w = (32'(f.opcode) << OP_LSB) | (32'(f.rs) << RS_LSB) |
                          (32'(f.rt) << RT_LSB) | 32'(f.imm);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Combinational instruction packer: encodes one beat of fields into a 32-bit
// word, substituting a nop for opcodes outside the legal set.
module instr_packer
    import imem_loader_pkg::*;
(
    input  instr_fields_t fields_i,
    output logic [31:0]   word_o,
    output logic          legal_o
);

    always_comb begin
        legal_o = is_legal_opcode(fields_i.opcode);
        word_o  = legal_o ? encode_instr(fields_i) : 32'h0;
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: accepts instruction field beats, packs them and writes them
// to consecutive imem word addresses starting at a latched base.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e       state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   widx_q;
    logic [ADDR_W:0]   count_q;
    logic              we_q;
    logic [ADDR_W-1:0] wa_q;
    logic [31:0]       wd_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    instr_fields_t     fields_d;
    logic [31:0]       word_d;
    logic              legal_d;

    assign fields_d = '{opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                        shamt: in_shamt, funct: in_funct, imm: in_imm,
                        target: in_target};

    instr_packer u_packer (
        .fields_i (fields_d),
        .word_o   (word_d),
        .legal_o  (legal_d)
    );

    // widx_q counts accepted writes immediately so back-to-back beats get
    // distinct addresses; count_q is its one-cycle-late public copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            widx_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= widx_q;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        widx_q  <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (widx_q == CAPACITY) begin
                            err_q <= 1'b1;
                        end else begin
                            we_q   <= 1'b1;
                            wa_q   <= base_q + widx_q[ADDR_W-1:0];
                            wd_q   <= word_d;
                            widx_q <= widx_q + ONE;
                            if (!legal_d) err_q <= 1'b1;
                        end
                        if (in_last) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_LOAD);
    assign imem_we  = we_q;
    assign imem_wa  = wa_q;
    assign imem_wd  = wd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a cycle-level session model checked on
// every falling edge, plus literal expectations for the directed programs.
module tb_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [5:0]    in_opcode = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          imem_we;
    logic [AW-1:0] imem_wa;
    logic [31:0]   imem_wd;
    logic          busy, done, err;
    logic [AW:0]   count;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we), .imem_wa(imem_wa),
        .imem_wd(imem_wd), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int ok_ops[19] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 15,
                       35, 36, 37, 40, 43, 48, 56};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    function automatic bit model_legal(input int op);
        for (int k = 0; k < 19; k++) if (ok_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int op, rs, rt, rd, sh, fn, imm, tgt);
        longint w;
        if (!model_legal(op)) return 32'h0;
        if (op == 0)
            w = longint'(rs) * (64'd1 << 21) + longint'(rt) * (64'd1 << 16) +
                longint'(rd) * (64'd1 << 11) + longint'(sh) * 64 + longint'(fn);
        else if (op == 2 || op == 3)
            w = longint'(op) * (64'd1 << 26) + longint'(tgt);
        else
            w = longint'(op) * (64'd1 << 26) + longint'(rs) * (64'd1 << 21) +
                longint'(rt) * (64'd1 << 16) + longint'(imm);
        return w[31:0];
    endfunction

    // Session model state and observations; written only by the compare process.
    int          m_phase = 0;      // 0 idle, 1 loading, 2 draining last write
    int          m_base = 0, m_n = 0, m_count = 0;
    bit          m_err = 0, m_we = 0, m_done = 0, m_busy = 0;
    logic [31:0] m_wa = 0, m_wd = 0;
    logic [31:0] mem [DEPTH];
    int          done_pulses = 0, sess_writes = 0, run = 0, max_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_base = 0; m_n = 0; m_count = 0;
            m_err = 0; m_we = 0; m_done = 0; m_busy = 0;
            chk("rst_in_ready", {31'd0, in_ready}, 0);
            chk("rst_we", {31'd0, imem_we}, 0);
            chk("rst_wa", 32'(imem_wa), 0);
            chk("rst_wd", imem_wd, 0);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_err", {31'd0, err}, 0);
            chk("rst_count", 32'(count), 0);
            run = 0;
        end else begin
            chk("we", {31'd0, imem_we}, {31'd0, m_we});
            if (m_we) begin
                chk("wa", 32'(imem_wa), m_wa);
                chk("wd", imem_wd, m_wd);
            end
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("count", 32'(count), 32'(m_count));
            chk("in_ready", {31'd0, in_ready}, (m_phase == 1) ? 32'd1 : 32'd0);

            if (imem_we === 1'b1) begin
                mem[imem_wa] = imem_wd;
                sess_writes++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done === 1'b1) done_pulses++;

            m_we = 0;
            m_done = 0;
            m_count = m_n;
            case (m_phase)
                0: if (start) begin
                    m_base = int'(base_addr); m_n = 0; m_err = 0; m_count = 0;
                    m_phase = 1;
                    for (int a = 0; a < DEPTH; a++) mem[a] = 32'hDEADBEEF;
                    sess_writes = 0; max_run = 0;
                end
                1: if (in_valid) begin
                    if (m_n == DEPTH) begin
                        m_err = 1;
                    end else begin
                        m_we = 1;
                        m_wa = 32'((m_base + m_n) % DEPTH);
                        m_wd = model_word(int'(in_opcode), int'(in_rs), int'(in_rt),
                                          int'(in_rd), int'(in_shamt), int'(in_funct),
                                          int'(in_imm), int'(in_target));
                        if (!model_legal(int'(in_opcode))) m_err = 1;
                        m_n++;
                    end
                    if (in_last) m_phase = 2;
                end
                default: begin
                    m_phase = 0;
                    m_done = 1;
                end
            endcase
            m_busy = (m_phase != 0);
        end
    end

    task automatic start_session(input int base);
        start = 1'b1;
        base_addr = AW'(base);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int op, rs, rt, rd, sh, fn, imm, tgt,
                        input bit last, input int gap);
        int  w;
        bit  ok;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_opcode = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm);
        in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            w++;
            if (w > 20) begin fail_now("accept_timeout"); break; end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 300) begin @(posedge clk); #1; w++; end
        if (busy) fail_now("idle_timeout");
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic send_random(input bit last, input int gap);
        int op;
        if ($urandom_range(7) == 0) begin
            op = int'($urandom_range(63));
            while (model_legal(op)) op = int'($urandom_range(63));
        end else begin
            op = ok_ops[$urandom_range(18)];
        end
        send(op, int'($urandom_range(31)), int'($urandom_range(31)),
             int'($urandom_range(31)), int'($urandom_range(31)),
             int'($urandom_range(63)), int'($urandom_range(65535)),
             int'($urandom_range(26'h3FFFFFF)), last, gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single R-type add
        d0 = done_pulses;
        start_session(0);
        send(0, 1, 2, 3, 0, 'h20, 0, 0, 1'b1, 0);
        wait_idle();
        chk("add_word", mem[0], 32'h00221820);
        chk("add_count", 32'(count), 1);
        chk("add_err", {31'd0, err}, 0);
        chk("add_done_pulses", 32'(done_pulses - d0), 1);

        // back-to-back I and J words
        start_session(0);
        send(8, 0, 8, 0, 0, 0, 5, 0, 1'b0, 0);
        send('h23, 8, 9, 0, 0, 0, 4, 0, 1'b0, 0);
        send(2, 0, 0, 0, 0, 0, 0, 'h10, 1'b0, 0);
        send(3, 0, 0, 0, 0, 0, 0, 'h10, 1'b1, 0);
        wait_idle();
        chk("addi_word", mem[0], 32'h20080005);
        chk("lw_word", mem[1], 32'h8D090004);
        chk("j_word", mem[2], 32'h08000010);
        chk("jal_word", mem[3], 32'h0C000010);
        chk("b2b_run", 32'(max_run), 4);
        chk("b2b_count", 32'(count), 4);

        // illegal opcode becomes a nop but still consumes an address
        start_session(0);
        send('h3F, 7, 7, 7, 7, 7, 'h1234, 0, 1'b0, 0);
        send(8, 0, 8, 0, 0, 0, 5, 0, 1'b1, 1);
        wait_idle();
        chk("illegal_nop", mem[0], 32'h00000000);
        chk("illegal_next", mem[1], 32'h20080005);
        chk("illegal_err", {31'd0, err}, 1);
        chk("illegal_count", 32'(count), 2);

        // address wrap from the top of memory
        start_session(62);
        for (int i = 1; i <= 3; i++) send(8, 0, 8, 0, 0, 0, i, 0, i == 3, 0);
        wait_idle();
        chk("wrap_62", mem[62], 32'h20080001);
        chk("wrap_63", mem[63], 32'h20080002);
        chk("wrap_0", mem[0], 32'h20080003);
        chk("wrap_err", {31'd0, err}, 0);

        // overflow: 65 beats into 64 words
        d0 = done_pulses;
        start_session(0);
        for (int i = 0; i < 65; i++) send(8, 0, 8, 0, 0, 0, i, 0, i == 64, 0);
        wait_idle();
        chk("ovf_count", 32'(count), 64);
        chk("ovf_err", {31'd0, err}, 1);
        chk("ovf_writes", 32'(sess_writes), 64);
        chk("ovf_last_word", mem[63], 32'h2008003F);
        chk("ovf_done_pulses", 32'(done_pulses - d0), 1);

        // randomized sessions with ~50% valid gaps and start held while busy
        for (int s = 0; s < 6; s++) begin
            start_session(int'($urandom_range(DEPTH - 1)));
            start = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (i == 9) start = 1'b0;
                send_random(i == 9, int'($urandom_range(1)));
            end
            wait_idle();
            chk("rand_writes", 32'(sess_writes), 10);
            chk("rand_count", 32'(count), 10);
        end

        // reset in the middle of a session
        start_session(5);
        for (int i = 0; i < 3; i++) send(8, 0, 8, 0, 0, 0, i, 0, 1'b0, 0);
        d0 = done_pulses;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_we", {31'd0, imem_we}, 0);
        chk("midrst_count", 32'(count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_no_done", 32'(done_pulses - d0), 0);
        start_session(10);
        send(8, 0, 8, 0, 0, 0, 7, 0, 1'b0, 0);
        send(8, 0, 8, 0, 0, 0, 8, 0, 1'b1, 0);
        wait_idle();
        chk("post_rst_wa10", mem[10], 32'h20080007);
        chk("post_rst_wa11", mem[11], 32'h20080008);
        chk("post_rst_count", 32'(count), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
